// File: rtl/seven_arb_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
// Optional preemption by requester 0 is enabled with SEVEN_ARB_PREEMPT_EN.
package seven_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_e;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned NIB_W   = 4;
    localparam int unsigned TEN_LSB = 4;
    localparam int unsigned ONE_LSB = 0;

    // Index width that stays legal for a single-entry vector.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping N-1 -> 0.
module rr_arbiter
    import seven_arb_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = idx_width(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o
);

    logic          found;
    logic [IW-1:0] cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = '0;
        for (int unsigned off = 0; off < N; off++) begin
            cand = IW'((32'(ptr_i) + off) % N);
            if (!found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
    end

endmodule

// File: rtl/seven_seg_display_arbiter.sv
// Round-robin sharing of a two-digit hex display; each accepted byte is held HOLD_CYCLES clocks.
// Define SEVEN_ARB_PREEMPT_EN to let requester 0 preempt another source while it is shown.
module seven_seg_display_arbiter
    import seven_arb_pkg::*;
#(
    parameter  int unsigned N_REQ       = 4,
    parameter  int unsigned DATA_W      = 8,
    parameter  int unsigned HOLD_CYCLES = 50_000_000,
    localparam int unsigned IW          = idx_width(N_REQ),
    localparam int unsigned TW          = $clog2(HOLD_CYCLES + 1)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [N_REQ-1:0]        i_req_valid,
    input  logic [N_REQ*DATA_W-1:0] i_req_data,
    output logic [N_REQ-1:0]        o_req_ready,
    output logic [NIB_W-1:0]        o_hex_ten,
    output logic [NIB_W-1:0]        o_hex_one,
    output logic [IW-1:0]           o_src_id,
    output logic                    o_busy
);

    state_e            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [DATA_W-1:0] byte_q, byte_d;
    logic [IW-1:0]     src_q, src_d;

    logic [N_REQ-1:0]  rr_grant;
    logic [IW-1:0]     rr_idx;
    logic [IW-1:0]     win_idx;
    logic [DATA_W-1:0] win_byte;
    logic              xfer;

    rr_arbiter #(
        .N (N_REQ)
    ) u_rr_arbiter (
        .req_i   (i_req_valid),
        .ptr_i   (ptr_q),
        .grant_o (rr_grant),
        .idx_o   (rr_idx)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ptr_q   <= '0;
            timer_q <= '0;
            byte_q  <= '0;
            src_q   <= '0;
        end else begin
            ptr_q   <= ptr_d;
            timer_q <= timer_d;
            byte_q  <= byte_d;
            src_q   <= src_d;
        end
    end

    always_comb begin
        win_byte = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (win_idx == IW'(k)) begin
                win_byte = i_req_data[k*DATA_W +: DATA_W];
            end
        end
    end

    assign xfer = |(o_req_ready & i_req_valid);

    // Next state: an accept always (re)starts a full hold; otherwise count down to 0.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        timer_d = timer_q;
        byte_d  = byte_q;
        src_d   = src_q;
        if (xfer) begin
            state_d = SHOW;
            byte_d  = win_byte;
            src_d   = win_idx;
            timer_d = TW'(HOLD_CYCLES - 1);
            ptr_d   = IW'((32'(win_idx) + 1) % N_REQ);
        end else if (state_q == SHOW) begin
            if (timer_q == '0) begin
                state_d = IDLE;
            end else begin
                timer_d = timer_q - TW'(1);
            end
        end
    end

    always_comb begin
        o_req_ready = '0;
        win_idx     = rr_idx;
        o_busy      = (state_q == SHOW);
        unique case (state_q)
            IDLE: o_req_ready = rr_grant;
            SHOW: begin
`ifdef SEVEN_ARB_PREEMPT_EN
                if (src_q != '0 && i_req_valid[0]) begin
                    o_req_ready = N_REQ'(1);
                    win_idx     = '0;
                end
`endif
            end
            default: ;
        endcase
    end

    assign o_hex_ten = byte_q[TEN_LSB +: NIB_W];
    assign o_hex_one = byte_q[ONE_LSB +: NIB_W];
    assign o_src_id  = src_q;

endmodule

// File: tb/tb_seven_seg_display_arbiter.sv
// Self-checking bench: cycle model plus display scoreboard, rotation table, directed corner cases.
module tb_seven_seg_display_arbiter;

    localparam int N = 4;
    localparam int H = 4;

`ifdef SEVEN_ARB_PREEMPT_EN
    localparam logic [3:0] PRE_READY = 4'b0001;
    localparam int         PRE_GAP   = 2;
`else
    localparam logic [3:0] PRE_READY = 4'b0000;
    localparam int         PRE_GAP   = H + 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  ready;
    logic [3:0]  ten;
    logic [3:0]  one;
    logic [1:0]  src;
    logic        busy;

    always #5 clk = ~clk;

    seven_seg_display_arbiter #(
        .N_REQ       (N),
        .DATA_W      (8),
        .HOLD_CYCLES (H)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (valid),
        .i_req_data  (data),
        .o_req_ready (ready),
        .o_hex_ten   (ten),
        .o_hex_one   (one),
        .o_src_id    (src),
        .o_busy      (busy)
    );

    typedef struct {
        logic [3:0] ten;
        logic [3:0] one;
        logic [1:0] src;
    } disp_t;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [1:0]  exp_src;
        logic [7:0]  exp_byte;
        int          exp_gap;
    } vec_t;

    disp_t sb[$];

    int         n_vec = 0;
    int         n_err = 0;
    bit         m_show;
    int         m_ptr;
    int         m_timer;
    int         m_src;
    logic [7:0] m_byte;
    int         cyc = 0;
    int         last_acc_cyc = 0;
    int         last_gap = 0;
    int         last_src = 0;
    bit         acc_now;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [3:0] model_ready();
        logic [3:0] r;
        bit         found;
        int         k;
        r     = 4'b0000;
        found = 1'b0;
        if (!m_show) begin
            for (int o = 0; o < N; o++) begin
                k = (m_ptr + o) % N;
                if (!found && valid[k]) begin
                    r[k]  = 1'b1;
                    found = 1'b1;
                end
            end
        end
`ifdef SEVEN_ARB_PREEMPT_EN
        else if (m_src != 0 && valid[0]) begin
            r = 4'b0001;
        end
`endif
        return r;
    endfunction

    function automatic void model_reset();
        m_show  = 1'b0;
        m_ptr   = 0;
        m_timer = 0;
        m_src   = 0;
        m_byte  = 8'h00;
        sb.delete();
    endfunction

    // One clock: check combinational outputs at negedge, registered outputs 1 after posedge.
    task automatic tick();
        logic [3:0] er;
        logic [7:0] b;
        int         w;
        disp_t      d;
        @(negedge clk);
        er = model_ready();
        chk("ready", 32'(ready), 32'(er));
        chk("busy", 32'(busy), 32'(m_show));
        w = -1;
        b = 8'h00;
        for (int k = 0; k < N; k++) if (er[k]) w = k;
        if (w >= 0) begin
            b = 8'(data >> (8 * w));
            sb.push_back('{b[7:4], b[3:0], 2'(w)});
        end
        @(posedge clk);
        #1;
        cyc++;
        acc_now = (w >= 0);
        if (acc_now) begin
            m_byte       = b;
            m_src        = w;
            m_timer      = H - 1;
            m_ptr        = (w + 1) % N;
            m_show       = 1'b1;
            last_gap     = cyc - last_acc_cyc;
            last_acc_cyc = cyc;
            last_src     = w;
            d = sb.pop_front();
            chk("sb_ten", 32'(ten), 32'(d.ten));
            chk("sb_one", 32'(one), 32'(d.one));
            chk("sb_src", 32'(src), 32'(d.src));
        end else begin
            if (m_show) begin
                if (m_timer == 0) m_show = 1'b0;
                else m_timer--;
            end
            chk("disp_byte", 32'({ten, one}), 32'(m_byte));
            chk("disp_src", 32'(src), 32'(m_src));
        end
    endtask

    task automatic wait_accept(input int bound);
        int n;
        n       = 0;
        acc_now = 1'b0;
        while (!acc_now && n < bound) begin
            tick();
            n++;
        end
        if (!acc_now) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: no grant within %0d cycles (cycle %0d)", bound, cyc);
        end
    endtask

    task automatic drain();
        int n;
        valid = 4'b0000;
        n     = 0;
        while (m_show && n < 12) begin
            tick();
            n++;
        end
        tick();
    endtask

    task automatic measure_busy(input string name);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 12) begin
            n++;
            tick();
        end
        chk(name, 32'(n), 32'(H));
    endtask

    task automatic do_reset(input string name);
        rst = 1'b1;
        #1;
        chk({name, "_busy"}, 32'(busy), 32'd0);
        chk({name, "_ten"}, 32'(ten), 32'd0);
        chk({name, "_one"}, 32'(one), 32'd0);
        chk({name, "_src"}, 32'(src), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    vec_t rot[5];

    initial begin
        rst   = 1'b0;
        valid = 4'b0000;
        data  = 32'h0;
        model_reset();
        #2;
        do_reset("init");
        chk("init_ready", 32'(ready), 32'd0);

        // Single request from requester 2.
        valid = 4'b0100;
        data  = 32'h003A_0000;
        wait_accept(8);
        chk("single_src", 32'(src), 32'd2);
        chk("single_byte", 32'({ten, one}), 32'h3A);
        valid = 4'b0000;
        measure_busy("single_busy_len");

        // Hold expiry with nothing pending retains the last byte.
        chk("hold_busy", 32'(busy), 32'd0);
        chk("hold_ten", 32'(ten), 32'h3);
        chk("hold_one", 32'(one), 32'hA);
        #1;
        chk("hold_ready", 32'(ready), 32'd0);
        tick();

        // Asynchronous reset in the middle of a hold.
        valid = 4'b1000;
        data  = 32'h5C00_0000;
        wait_accept(8);
        valid = 4'b0000;
        tick();
        tick();
        do_reset("mid");
        valid = 4'b0010;
        data  = 32'h0000_2100;
        #1;
        chk("rst_ready", 32'(ready), 32'b0010);
        wait_accept(4);
        chk("rst_src", 32'(src), 32'd1);
        drain();

        // Strict rotation with all requesters valid, from pointer 0.
        do_reset("rot");
        for (int i = 0; i < 5; i++) begin
            rot[i].valid    = 4'b1111;
            rot[i].data     = 32'h1312_1110;
            rot[i].exp_src  = 2'(i % 4);
            rot[i].exp_byte = 8'h10 + 8'(i % 4);
            rot[i].exp_gap  = (i == 0) ? 0 : H + 1;
        end
        for (int i = 0; i < 5; i++) begin
            valid = rot[i].valid;
            data  = rot[i].data;
            wait_accept(12);
            chk("rot_src", 32'(src), 32'(rot[i].exp_src));
            chk("rot_byte", 32'({ten, one}), 32'(rot[i].exp_byte));
            if (rot[i].exp_gap != 0) chk("rot_gap", 32'(last_gap), 32'(rot[i].exp_gap));
        end
        drain();

        // A valid pulse during a hold is not remembered.
        valid = 4'b0001;
        data  = 32'h0066_0044;
        wait_accept(8);
        chk("drop_first", 32'(src), 32'd0);
        valid = 4'b0000;
        tick();
        valid = 4'b0010;
        tick();
        valid = 4'b0000;
        tick();
        valid = 4'b0101;
        wait_accept(12);
        chk("drop_next_src", 32'(src), 32'd2);
        chk("drop_next_byte", 32'({ten, one}), 32'h66);
        drain();

        // Requester 0 arrives while source 3 is shown.
        valid = 4'b1000;
        data  = 32'h3300_0000;
        wait_accept(8);
        chk("pre_src3", 32'(src), 32'd3);
        valid = 4'b0000;
        tick();
        valid = 4'b0001;
        data  = 32'h0000_0077;
        #2;
        chk("pre_ready", 32'(ready), 32'(PRE_READY));
        wait_accept(12);
        chk("pre_src0", 32'(src), 32'd0);
        chk("pre_byte", 32'({ten, one}), 32'h77);
        chk("pre_gap", 32'(last_gap), 32'(PRE_GAP));
        valid = 4'b0000;
        measure_busy("pre_busy_len");
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
